// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared widths, reset level, fetch FSM encodings and PC helper
package if_fetch_pkg;
   localparam int INST_ADDR_BUS = 32;
   localparam int INST_BUS = 32;
   localparam int ENTRY_W = INST_ADDR_BUS + INST_BUS;
   localparam logic [INST_BUS-1:0] ZERO_WORD = '0;
   localparam logic RST_ENABLE = 1'b1;
   typedef enum logic [1:0] {
      FETCH_IDLE = 2'd0,
      FETCH_WAIT = 2'd1,
      FETCH_DISCARD = 2'd2
   } fetch_state_t;
   function automatic logic [INST_ADDR_BUS-1:0] pc_inc(input logic [INST_ADDR_BUS-1:0] a);
      return a + 32'd4;
   endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous {pc, inst} prefetch buffer; flush beats push and pop
module fetch_fifo
   import if_fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [ENTRY_W-1:0]       din,
   output logic [ENTRY_W-1:0]       head,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   assign head = mem[rp];
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[wp] <= din;
            wp <= wp + AW'(1);
         end
         if (pop) rp <= rp + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end
   always_ff @(posedge clk) begin
      if (rst != RST_ENABLE && push && !flush)
         assert (count < CW'(DEPTH)) else $error("fetch_fifo push while full");
   end
endmodule

// File: rtl/if_fetch.sv
// if_fetch: PC generation, single-outstanding imem fetch FSM and prefetch buffer
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        branch_flag,
   input  logic [31:0] branch_target,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_valid
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   fetch_state_t st, st_n;
   logic [INST_ADDR_BUS-1:0] pc, pc_n, req_addr, ra_n, tgt;
   logic [CW-1:0] count, cnt_nx;
   logic [ENTRY_W-1:0] head;
   logic push, pop, room;
   assign tgt = {branch_target[31:2], 2'b00};
   assign if_valid = count != '0;
   assign if_pc = head[ENTRY_W-1:INST_BUS];
   assign if_inst = head[INST_BUS-1:0];
   assign imem_req = st != FETCH_IDLE;
   assign imem_addr = req_addr;
   assign pop = if_valid && !stall && !branch_flag;
   assign push = st == FETCH_WAIT && imem_ack && !branch_flag;
   // one request outstanding, so room is judged after this cycle's push/pop
   assign cnt_nx = count + CW'(push) - CW'(pop);
   assign room = cnt_nx < CW'(FIFO_DEPTH);
   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .rst(rst),
      .push(push),
      .pop(pop),
      .flush(branch_flag),
      .din({req_addr, imem_rdata}),
      .head(head),
      .count(count)
   );
   always_comb begin
      st_n = st;
      pc_n = branch_flag ? tgt : pc;
      ra_n = req_addr;
      case (st)
         FETCH_IDLE: begin
            ra_n = (!branch_flag && room) ? pc : req_addr;
            st_n = (!branch_flag && room) ? FETCH_WAIT : FETCH_IDLE;
         end
         FETCH_WAIT: begin
            if (branch_flag) st_n = imem_ack ? FETCH_IDLE : FETCH_DISCARD;
            else if (imem_ack) begin
               pc_n = pc_inc(req_addr);
               ra_n = room ? pc_inc(req_addr) : req_addr;
               st_n = room ? FETCH_WAIT : FETCH_IDLE;
            end
         end
         // address held on the bus until the abandoned fetch is acked
         FETCH_DISCARD: st_n = imem_ack ? FETCH_IDLE : FETCH_DISCARD;
         default: st_n = FETCH_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         st <= FETCH_IDLE;
         pc <= RESET_PC;
         req_addr <= ZERO_WORD;
      end else begin
         st <= st_n;
         pc <= pc_n;
         req_addr <= ra_n;
      end
   end
endmodule
